uart_word_rx: RTL

Serial-to-word front end for the UART instruction path, sitting directly upstream of the UART register-file block. It deserialises 8N1 frames from the host pin and packs four bytes, least-significant byte first, into one 32-bit RISC-V instruction word. It offers each word on a valid/ready handshake to the consumer that drives the processor instruction input. It also reports framing errors and overruns, and discards partial words after host silence.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_word_rx_if.sv | 26 ++
 rtl/uart_rx_byte.sv | 127 ++++++++++++
 rtl/uart_word_rx.sv | 105 ++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART word receiver
//
// Purpose: bit-FSM state encoding plus the frame and word geometry that
//          uart_rx_byte and uart_word_rx both rely on.
// Ports:   none (package).
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } rx_state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int BITS_PER_FRAME = 8;

endpackage

// File: rtl/uart_word_rx_if.sv
// rtl/uart_word_rx_if.sv - valid/ready word channel from the receiver to its consumer
//
// Purpose: carries one assembled 32-bit word per handshake.
// Signals: word_data  - assembled word, byte k in bits [8k+7:8k]
//          word_valid - word_data holds an unconsumed word
//          word_ready - consumer accepts when word_valid && word_ready
// Modports: master (receiver side), slave (consumer side).
interface uart_word_rx_if;

    logic [31:0] word_data;
    logic        word_valid;
    logic        word_ready;

    modport master (
        output word_data,
        output word_valid,
        input  word_ready
    );

    modport slave (
        input  word_data,
        input  word_valid,
        output word_ready
    );

endinterface

// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - 8N1 byte deserialiser with input synchroniser
//
// Purpose: synchronises rx, detects start bits, samples eight data bits LSB
//          first at mid-bit and checks the stop bit.
// Ports:   clk, rst_n    - clock, asynchronous active-low reset
//          rx            - raw serial line, idle high
//          byte_data     - last deserialised byte (valid with byte_valid)
//          byte_valid    - one-cycle pulse, good stop bit seen
//          frame_err     - one-cycle pulse, stop bit sampled low
//          in_idle       - bit FSM is in IDLE
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       frame_err,
    output logic       in_idle
);

    localparam int CW = $clog2(CLKS_PER_BIT);

    localparam logic [2:0] S_IDLE      = IDLE;
    localparam logic [2:0] S_START     = START;
    localparam logic [2:0] S_DATA      = DATA;
    localparam logic [2:0] S_STOP      = STOP;
    localparam logic [2:0] S_WAIT_IDLE = WAIT_IDLE;

    localparam logic [CW-1:0] FULL_BIT = CW'(CLKS_PER_BIT - 1);
    // Half a bit lands the first sample mid start bit; every later sample
    // is a whole bit further on, so all samples sit mid-bit.
    localparam logic [CW-1:0] HALF_BIT = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]    LAST_BIT = 3'(BITS_PER_FRAME - 1);

    logic          sync1;
    logic          rxs;
    logic          armed;
    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1      <= 1'b1;
            rxs        <= 1'b1;
            armed      <= 1'b0;
            state      <= S_IDLE;
            cnt        <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            sync1      <= rx;
            rxs        <= sync1;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    // Arming needs a high line first, so a line held low
                    // through reset release never looks like a start bit.
                    if (armed && !rxs) begin
                        state <= S_START;
                        cnt   <= HALF_BIT;
                        armed <= 1'b0;
                    end else if (rxs) begin
                        armed <= 1'b1;
                    end
                end
                S_START: begin
                    if (cnt == '0) begin
                        if (rxs) begin
                            state <= S_IDLE;
                        end else begin
                            state   <= S_DATA;
                            bit_cnt <= '0;
                            cnt     <= FULL_BIT;
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_DATA: begin
                    if (cnt == '0) begin
                        shreg <= {rxs, shreg[7:1]};
                        cnt   <= FULL_BIT;
                        if (bit_cnt == LAST_BIT) begin
                            state <= S_STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_STOP: begin
                    if (cnt == '0) begin
                        if (rxs) begin
                            byte_valid <= 1'b1;
                            state      <= S_IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= S_WAIT_IDLE;
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_WAIT_IDLE: begin
                    if (rxs) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign byte_data = shreg;
    assign in_idle   = (state == S_IDLE);

endmodule

// File: rtl/uart_word_rx.sv
// rtl/uart_word_rx.sv - UART byte stream to 32-bit instruction word front end
//
// Purpose: packs four good bytes LSB first into a word, offers it on a
//          valid/ready channel with a one-deep holding slot, reports
//          framing errors and overruns, and drops partial words after
//          TIMEOUT_BITS bit-times of idle line.
// Ports:   clk, rst_n - clock, asynchronous active-low reset
//          rx         - raw serial line, idle high
//          word       - word channel (master side)
//          frame_err  - one-cycle pulse, stop bit sampled low
//          overrun    - one-cycle pulse, completed word dropped (slot full)
//          busy       - bit FSM active or 1-3 bytes held
module uart_word_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           rx,
    uart_word_rx_if.master word,
    output logic           frame_err,
    output logic           overrun,
    output logic           busy
);

    localparam int LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TW    = $clog2(LIMIT + 1);

    logic [7:0]    byte_data;
    logic          byte_valid;
    logic          in_idle;
    logic [1:0]    byte_idx;
    logic [23:0]   lanes;
    logic [TW-1:0] idle_cnt;
    logic          word_done;
    logic          timeout_hit;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx_byte (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .byte_data (byte_data),
        .byte_valid(byte_valid),
        .frame_err (frame_err),
        .in_idle   (in_idle)
    );

    assign word_done   = byte_valid && (byte_idx == 2'(BYTES_PER_WORD - 1));
    assign timeout_hit = (idle_cnt == TW'(LIMIT));
    assign busy        = !in_idle || (byte_idx != 2'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_idx        <= '0;
            lanes           <= '0;
            idle_cnt        <= '0;
            overrun         <= 1'b0;
            word.word_data  <= '0;
            word.word_valid <= 1'b0;
        end else begin
            overrun <= 1'b0;

            // Byte assembly; a bad frame or a silent host restarts the word.
            if (frame_err) begin
                byte_idx <= '0;
            end else if (byte_valid) begin
                case (byte_idx)
                    2'd0:    lanes[7:0]   <= byte_data;
                    2'd1:    lanes[15:8]  <= byte_data;
                    2'd2:    lanes[23:16] <= byte_data;
                    default: ;
                endcase
                byte_idx <= byte_idx + 2'd1;
            end else if (timeout_hit) begin
                byte_idx <= '0;
            end

            // Only counts while the line is idle with a partial word held;
            // leaving IDLE means a start bit was detected.
            if (!in_idle || byte_idx == 2'd0 || timeout_hit) begin
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + TW'(1);
            end

            // Holding slot: a completing word may replace one being consumed
            // in the same cycle; otherwise it is dropped and flagged.
            if (word_done) begin
                if (!word.word_valid || word.word_ready) begin
                    word.word_data  <= {byte_data, lanes};
                    word.word_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (word.word_ready) begin
                word.word_valid <= 1'b0;
            end
        end
    end

endmodule
